// File: rtl/prbs_stream_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs_stream_scheduler_pkg
// Description : Shared encodings for the PRBS/data readout scheduler: mode
//               codes, output source codes, default orbit length and filler
//               word, FSM state type and small mode-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs_stream_scheduler_pkg;

    // Requested / applied mode encodings
    localparam logic [1:0] c_MODE_OFF  = 2'b00;
    localparam logic [1:0] c_MODE_PRBS = 2'b01;
    localparam logic [1:0] c_MODE_DATA = 2'b10;
    localparam logic [1:0] c_MODE_MIX  = 2'b11;

    // word_src encodings
    localparam logic [1:0] c_SRC_NONE   = 2'b00;
    localparam logic [1:0] c_SRC_PRBS   = 2'b01;
    localparam logic [1:0] c_SRC_DATA   = 2'b10;
    localparam logic [1:0] c_SRC_FILLER = 2'b11;

    // Defaults
    localparam int          c_ORBIT_LEN_DEF = 3564;
    localparam logic [15:0] c_FILLER_DEF    = 16'h3C5C;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ARM = 2'd1,
        ST_RUN = 2'd2
    } state_t;

    // Modes in which the generator word appears on the output, so its BCID
    // must track the local one.
    function automatic logic mode_checks_bcid(input logic [1:0] mode);
        return (mode == c_MODE_PRBS) || (mode == c_MODE_MIX);
    endfunction

    // Modes in which the hit-data path is drained.
    function automatic logic mode_takes_data(input logic [1:0] mode);
        return (mode == c_MODE_DATA) || (mode == c_MODE_MIX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_stream_scheduler_orbit_counter.sv
`default_nettype none
// ============================================================================
// Module      : prbs_stream_scheduler_orbit_counter
// Description : Local BCID counter wrapping at ORBIT_LEN-1 plus a completed
//               orbit counter. Both clear synchronously on reset or clr.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               clr             - synchronous clear of bcid and orbit_count
//               en              - advance bcid this cycle
//               bcid            - current local BCID
//               orbit_count     - completed orbits, wraps silently
//               wrap            - high on the enabled cycle where bcid is last
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_stream_scheduler_orbit_counter
    import prbs_stream_scheduler_pkg::*;
#(
    parameter int ORBIT_LEN = c_ORBIT_LEN_DEF,
    parameter int BCID_W    = 12,
    parameter int OCNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [BCID_W-1:0] bcid,
    output logic [OCNT_W-1:0] orbit_count,
    output logic              wrap
);

    localparam logic [BCID_W-1:0] c_BCID_LAST = BCID_W'(ORBIT_LEN - 1);

    logic [BCID_W-1:0] r_bcid;
    logic [OCNT_W-1:0] r_orbit_count;

    assign wrap        = en && (r_bcid == c_BCID_LAST);
    assign bcid        = r_bcid;
    assign orbit_count = r_orbit_count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_bcid        <= '0;
            r_orbit_count <= '0;
        end else if (en) begin
            if (wrap) begin
                r_bcid        <= '0;
                r_orbit_count <= r_orbit_count + OCNT_W'(1);
            end else begin
                r_bcid <= r_bcid + BCID_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : prbs_stream_scheduler
// Description : Shares the serializer word slot between the PRBS generator
//               and the hit-data path. Owns generator disable/restart, keeps
//               a local BCID, and applies mode changes only at orbit wraps.
// Ports       : clk, reset      - 40 MHz clock, synchronous active-high reset
//               mode_cfg        - requested mode (OFF/PRBS/DATA/MIX)
//               prbs_in         - current generator word
//               prbs_bcid       - generator BCID, checked against local bcid
//               prbs_dis        - freezes the generator
//               prbs_restart    - one-cycle generator reseed / BCID zero
//               data_in         - hit-data word
//               data_valid      - hit-data word available
//               data_ready      - hit-data word consumed when also valid
//               word_out        - registered serializer word
//               word_valid      - word_out meaningful
//               word_src        - NONE/PRBS/DATA/FILLER
//               active_mode     - mode currently applied
//               bcid            - local BCID
//               orbit_count     - completed orbits since the last ARM
//               bcid_err        - sticky generator/local BCID mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_stream_scheduler
    import prbs_stream_scheduler_pkg::*;
#(
    parameter int                ORBIT_LEN = c_ORBIT_LEN_DEF,
    parameter int                BCID_W    = 12,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] FILLER    = DATA_W'(c_FILLER_DEF),
    parameter int                OCNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode_cfg,
    input  logic [DATA_W-1:0] prbs_in,
    input  logic [BCID_W-1:0] prbs_bcid,
    output logic              prbs_dis,
    output logic              prbs_restart,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic [1:0]        word_src,
    output logic [1:0]        active_mode,
    output logic [BCID_W-1:0] bcid,
    output logic [OCNT_W-1:0] orbit_count,
    output logic              bcid_err
);

    state_t            r_state;
    logic [1:0]        r_active_mode;
    logic              r_prbs_dis;
    logic              r_prbs_restart;
    logic [DATA_W-1:0] r_word_out;
    logic              r_word_valid;
    logic [1:0]        r_word_src;
    logic              r_bcid_err;

    logic              w_run;
    logic              w_wrap;
    logic              w_take;
    logic [BCID_W-1:0] w_bcid;
    logic [DATA_W-1:0] w_next_word;
    logic [1:0]        w_next_src;

    assign w_run = (r_state == ST_RUN);

    // ------------------------------------------------------------------------
    // Local BCID / orbit counting; counting only advances in RUN and the ARM
    // cycle zeroes it so it lines up with the generator after restart.
    // ------------------------------------------------------------------------
    prbs_stream_scheduler_orbit_counter #(
        .ORBIT_LEN (ORBIT_LEN),
        .BCID_W    (BCID_W),
        .OCNT_W    (OCNT_W)
    ) u_orbit_counter (
        .clk         (clk),
        .reset       (reset),
        .clr         (r_state == ST_ARM),
        .en          (w_run),
        .bcid        (w_bcid),
        .orbit_count (orbit_count),
        .wrap        (w_wrap)
    );

    // Data is drained only while actually running a data-carrying mode.
    assign data_ready = w_run && mode_takes_data(r_active_mode);
    assign w_take     = data_valid && data_ready;

    // ------------------------------------------------------------------------
    // Word selection for the current cycle; registered below.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_word = '0;
        w_next_src  = c_SRC_NONE;
        case (r_active_mode)
            c_MODE_PRBS: begin
                w_next_word = prbs_in;
                w_next_src  = c_SRC_PRBS;
            end
            c_MODE_DATA: begin
                w_next_word = w_take ? data_in    : FILLER;
                w_next_src  = w_take ? c_SRC_DATA : c_SRC_FILLER;
            end
            c_MODE_MIX: begin
                w_next_word = w_take ? data_in    : prbs_in;
                w_next_src  = w_take ? c_SRC_DATA : c_SRC_PRBS;
            end
            default: begin
                w_next_word = '0;
                w_next_src  = c_SRC_NONE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered generator controls and output word.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_OFF;
            r_active_mode  <= c_MODE_OFF;
            r_prbs_dis     <= 1'b1;
            r_prbs_restart <= 1'b0;
            r_word_out     <= '0;
            r_word_valid   <= 1'b0;
            r_word_src     <= c_SRC_NONE;
            r_bcid_err     <= 1'b0;
        end else begin
            r_prbs_restart <= 1'b0;
            r_word_valid   <= w_run;
            r_word_out     <= w_run ? w_next_word : '0;
            r_word_src     <= w_run ? w_next_src  : c_SRC_NONE;

            if (w_run && mode_checks_bcid(r_active_mode) && (prbs_bcid != w_bcid)) begin
                r_bcid_err <= 1'b1;
            end

            case (r_state)
                ST_OFF: begin
                    r_prbs_dis <= 1'b1;
                    if (mode_cfg != c_MODE_OFF) begin
                        r_state        <= ST_ARM;
                        r_active_mode  <= mode_cfg;
                        r_prbs_restart <= 1'b1;
                        r_prbs_dis     <= 1'b0;
                    end
                end
                ST_ARM: begin
                    r_prbs_dis <= 1'b0;
                    r_bcid_err <= 1'b0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    r_prbs_dis <= 1'b0;
                    // mode_cfg is only looked at on the orbit's last BX
                    if (w_wrap) begin
                        if (mode_cfg == c_MODE_OFF) begin
                            r_state       <= ST_OFF;
                            r_active_mode <= c_MODE_OFF;
                            r_prbs_dis    <= 1'b1;
                        end else if (mode_cfg != r_active_mode) begin
                            r_state        <= ST_ARM;
                            r_active_mode  <= mode_cfg;
                            r_prbs_restart <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_OFF;
                    r_prbs_dis <= 1'b1;
                end
            endcase
        end
    end

    assign prbs_dis     = r_prbs_dis;
    assign prbs_restart = r_prbs_restart;
    assign word_out     = r_word_out;
    assign word_valid   = r_word_valid;
    assign word_src     = r_word_src;
    assign active_mode  = r_active_mode;
    assign bcid         = w_bcid;
    assign bcid_err     = r_bcid_err;

endmodule
`default_nettype wire

// File: tb/tb_prbs_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs_stream_scheduler
// Description : Randomized scoreboard bench for prbs_stream_scheduler with a
//               behavioural model of the mode/orbit rules and a generator
//               model driven by prbs_dis / prbs_restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_stream_scheduler;

    localparam int          L    = 3564;
    localparam logic [15:0] FILL = 16'h3C5C;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode_cfg;
    logic [15:0] prbs_in;
    logic [11:0] prbs_bcid;
    logic        prbs_dis;
    logic        prbs_restart;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] word_out;
    logic        word_valid;
    logic [1:0]  word_src;
    logic [1:0]  active_mode;
    logic [11:0] bcid;
    logic [15:0] orbit_count;
    logic        bcid_err;

    always #5 clk = ~clk;

    prbs_stream_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .mode_cfg     (mode_cfg),
        .prbs_in      (prbs_in),
        .prbs_bcid    (prbs_bcid),
        .prbs_dis     (prbs_dis),
        .prbs_restart (prbs_restart),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_src     (word_src),
        .active_mode  (active_mode),
        .bcid         (bcid),
        .orbit_count  (orbit_count),
        .bcid_err     (bcid_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = off, 1 = arming, 2 = running
    int          m_phase    = 0;
    logic [1:0]  m_mode     = 2'b00;
    int          m_pos      = 0;
    int          m_orb      = 0;
    bit          m_err      = 1'b0;
    bit          m_vld      = 1'b0;
    int          m_consumed = 0;
    int          tb_consumed = 0;
    logic [17:0] sb[$];
    bit          started    = 1'b0;

    // Generator model and stimulus knobs
    int          gen_bcid = 0;
    logic [1:0]  g_cfg    = 2'b00;
    int          g_dv     = 0;      // 0 random, 1 toggle, 2 low, 3 high
    bit          g_fix    = 1'b0;
    logic [15:0] g_din    = 16'h0000;
    bit          g_noise  = 1'b0;
    bit          g_inj    = 1'b0;
    bit          dv_tog   = 1'b0;

    task automatic model_step();
        logic [17:0] e;
        if (reset) begin
            m_phase = 0; m_mode = 2'b00; m_pos = 0; m_orb = 0; m_err = 1'b0; m_vld = 1'b0;
            return;
        end
        case (m_phase)
            0: begin
                m_vld = 1'b0;
                if (mode_cfg != 2'b00) begin
                    m_phase = 1;
                    m_mode  = mode_cfg;
                end
            end
            1: begin
                m_vld = 1'b0; m_phase = 2; m_pos = 0; m_orb = 0; m_err = 1'b0;
            end
            default: begin
                m_vld = 1'b1;
                case (m_mode)
                    2'b01:   e = {prbs_in, 2'b01};
                    2'b10:   e = data_valid ? {data_in, 2'b10} : {FILL, 2'b11};
                    default: e = data_valid ? {data_in, 2'b10} : {prbs_in, 2'b01};
                endcase
                sb.push_back(e);
                if ((m_mode == 2'b01 || m_mode == 2'b11) && (int'(prbs_bcid) != m_pos)) m_err = 1'b1;
                if (m_mode != 2'b01 && data_valid) m_consumed++;
                if (m_pos == L - 1) begin
                    m_pos = 0;
                    m_orb = (m_orb + 1) % 65536;
                    if (mode_cfg == 2'b00) begin
                        m_phase = 0; m_mode = 2'b00;
                    end else if (mode_cfg != m_mode) begin
                        m_phase = 1; m_mode = mode_cfg;
                    end
                end else begin
                    m_pos++;
                end
            end
        endcase
    endtask

    // One clock: drive inputs, advance on posedge, return on the next negedge.
    task automatic cycle();
        logic [1:0] cfg;
        logic       rs, ds, dr;
        cfg = g_cfg;
        if (g_noise && m_phase == 2 && m_pos != L - 1 && !reset) cfg = 2'($urandom);
        mode_cfg = cfg;
        case (g_dv)
            0: data_valid = 1'($urandom_range(0, 1));
            1: begin dv_tog = !dv_tog; data_valid = dv_tog; end
            2: data_valid = 1'b0;
            default: data_valid = 1'b1;
        endcase
        data_in   = g_fix ? g_din : 16'($urandom);
        prbs_in   = 16'($urandom);
        prbs_bcid = 12'(gen_bcid + (g_inj ? 1 : 0));
        rs = prbs_restart;
        ds = prbs_dis;
        dr = data_ready;
        @(posedge clk);
        if (data_valid && dr === 1'b1) tb_consumed++;
        if (rs === 1'b1)      gen_bcid = 0;
        else if (ds === 1'b0) gen_bcid = (gen_bcid == L - 1) ? 0 : gen_bcid + 1;
        model_step();
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        while (!(m_phase == 2 && m_pos == p) && k < 2 * L + 20) begin
            cycle();
            k++;
        end
        if (!(m_phase == 2 && m_pos == p)) begin
            n_tests++; n_fail++;
            $display("FAIL wait_pos: bcid %0d not reached, dut bcid %0d", p, bcid);
        end else begin
            chk("bcid_at_target", 32'(bcid), 32'(p));
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("word_valid", 32'(word_valid), 32'(m_vld));
                if (word_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL scoreboard: unexpected word %0h src %0h, required none", word_out, word_src);
                    end else begin
                        e = sb.pop_front();
                        chk("word_out", 32'(word_out), 32'(e[17:2]));
                        chk("word_src", 32'(word_src), 32'(e[1:0]));
                    end
                end
                chk("bcid",         32'(bcid),         32'(m_pos));
                chk("active_mode",  32'(active_mode),  32'(m_mode));
                chk("orbit_count",  32'(orbit_count),  32'(m_orb));
                chk("bcid_err",     32'(bcid_err),     32'(m_err));
                chk("prbs_dis",     32'(prbs_dis),     32'(m_phase == 0));
                chk("prbs_restart", 32'(prbs_restart), 32'(m_phase == 1));
                chk("data_ready",   32'(data_ready),
                    32'(m_phase == 2 && (m_mode == 2'b10 || m_mode == 2'b11)));
            end
        end
    end

    initial begin
        int k;
        reset = 1'b1; mode_cfg = 2'b00; prbs_in = '0; prbs_bcid = '0;
        data_in = '0; data_valid = 1'b0;
        @(negedge clk);
        repeat (2) cycle();
        reset = 1'b0;
        repeat (4) cycle();

        // PRBS for three orbits, with ignored mid-orbit mode_cfg noise
        g_cfg = 2'b01; g_noise = 1'b1;
        repeat (3 * L + 10) cycle();

        // Switch to DATA requested at bcid 100, applied at the wrap
        wait_pos(100);
        g_noise = 1'b0; g_cfg = 2'b10; g_dv = 1; g_fix = 1'b1; g_din = 16'h1234;
        wait_pos(0);
        repeat (200) cycle();

        // MIX: no data -> PRBS words, then BEEF words, then random traffic
        g_cfg = 2'b11; g_dv = 2; g_fix = 1'b0;
        wait_pos(0);
        repeat (50) cycle();
        g_dv = 3; g_fix = 1'b1; g_din = 16'hBEEF;
        repeat (5) cycle();
        g_dv = 0; g_fix = 1'b0; g_noise = 1'b1;
        repeat (300) cycle();

        // PRBS with one corrupted generator BCID at 2000; sticky until ARM
        g_cfg = 2'b01;
        wait_pos(0);
        wait_pos(2000);
        g_inj = 1'b1;
        cycle();
        g_inj = 1'b0;
        wait_pos(2000);
        g_cfg = 2'b11;
        wait_pos(0);

        // Reset mid-orbit in MIX, then re-arm
        wait_pos(1500);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (100) cycle();

        // Back to OFF at the next wrap
        g_cfg = 2'b00; g_noise = 1'b0;
        k = 0;
        while (m_phase != 0 && k < 2 * L + 20) begin
            cycle();
            k++;
        end
        repeat (10) cycle();

        #1;
        chk("consumed_beats", 32'(tb_consumed), 32'(m_consumed));
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs_stream_scheduler.md
Name: prbs_stream_scheduler

Overview:
- Sequences the 16-bit-per-clock PRBS test-pattern generator and shares the readout word slot between it and the hit-data path.
- Owns the generator's disable, restart and orbit alignment, and keeps a local BCID.
- Selects, per 40 MHz cycle, whether the serializer word is a data word, a PRBS word or filler.
- Mode changes take effect only at orbit boundaries.

Parameters:
ORBIT_LEN, 3564, cycles per orbit; BCID wraps at ORBIT_LEN-1
BCID_W, 12, BCID counter width
DATA_W, 16, word width of data, PRBS and output
FILLER, 16'h3C5C, word emitted in DATA mode when no data is valid
OCNT_W, 16, orbit counter width

Ports:
clk  in  1  40 MHz clock
reset  in  1  synchronous, active-high
mode_cfg  in  2  requested mode: 00 OFF, 01 PRBS, 10 DATA, 11 MIX (data, PRBS fill)
prbs_in  in  DATA_W  current generator word
prbs_bcid  in  BCID_W  generator BCID counter
prbs_dis  out  1  freezes generator when 1
prbs_restart  out  1  one-cycle pulse; generator reloads seed and zeroes its BCID on that edge
data_in  in  DATA_W  data word
data_valid  in  1  data word available
data_ready  out  1  data word consumed this cycle when data_valid&data_ready
word_out  out  DATA_W  registered output word
word_valid  out  1  word_out meaningful
word_src  out  2  00 none, 01 PRBS, 10 DATA, 11 FILLER
active_mode  out  2  mode currently applied
bcid  out  BCID_W  local BCID
orbit_count  out  OCNT_W  completed orbits since last ARM, wraps at 2^OCNT_W
bcid_err  out  1  sticky generator/local BCID mismatch

Behaviour:
- Reset (synchronous, high), and next cycle: state OFF, prbs_dis=1, prbs_restart=0, data_ready=0, word_out=0, word_valid=0, word_src=00, active_mode=00, bcid=0, orbit_count=0, bcid_err=0. Reset wins over every other event, including mid-orbit.
- FSM states OFF, ARM, RUN.
- OFF:
  - prbs_dis=1, data_ready=0, word_valid=0.
  - If mode_cfg!=00: go to ARM and latch active_mode=mode_cfg.
- ARM (exactly 1 cycle):
  - prbs_restart=1, prbs_dis=0.
  - Set bcid=0, orbit_count=0, bcid_err=0; go to RUN.
- RUN:
  - prbs_dis=0.
  - bcid increments every cycle. At bcid==ORBIT_LEN-1 it wraps to 0 and orbit_count increments.
  - At the wrap cycle, sample mode_cfg:
    - 00: go to OFF; active_mode=00.
    - Differs from active_mode: go to ARM with the new mode latched.
    - Otherwise: stay in RUN.
  - mode_cfg changes mid-orbit are ignored.
- Output selection in RUN, registered, one cycle latency from the inputs:
  - PRBS: word_out=prbs_in, src=01, data_ready=0.
  - DATA: data_ready=1 (combinational). On data_valid: word_out=data_in, src=10; else word_out=FILLER, src=11.
  - MIX: data_ready=1. On data_valid: data_in, src=10; else prbs_in, src=01.
  - word_valid=1 on every cycle following a RUN cycle; 0 otherwise.
- Generator is not disabled in DATA mode; it keeps free-running so alignment survives mode changes.
- data_ready=0 in OFF/ARM; no data is consumed there.
- BCID check:
  - In RUN with active_mode PRBS or MIX, prbs_bcid is compared to local bcid each cycle.
  - A mismatch sets bcid_err, which stays set until reset or ARM.
  - The generator's own BCID equals local bcid after ARM because of the restart pulse.
- Width rules:
  - bcid compare is unsigned and full width.
  - orbit_count wraps silently.
- Simultaneous events:
  - Wrap cycle with mode change: the wrap-cycle output follows the old mode. The ARM-cycle output is invalid (word_valid=0 one cycle later).

Decomposition:
- Shared package holds the mode encodings (MODE_OFF/PRBS/DATA/MIX), word_src encodings, ORBIT_LEN and FILLER defaults, and the FSM state typedef.
- One natural sub-module: orbit_counter, the bcid wrap counter plus orbit_count with a clear input and a wrap strobe. The FSM and output mux stay in the top.

Test Plan:
- Reset, then mode_cfg=01 -> prbs_dis 1→0; prbs_restart high exactly 1 cycle; bcid=0 in first RUN cycle; word_src=01 from next cycle; bcid_err stays 0 over 3 orbits with a correct generator model.
- mode_cfg=10, data_valid toggled every other cycle with data_in=16'h1234 -> words alternate 1234 (src 10) and 3C5C (src 11) with 1-cycle latency; a beat is consumed only on valid&ready.
- mode_cfg=11, data_valid low -> PRBS words (src 01); raise data_valid with 16'hBEEF -> next word BEEF, src 10.
- Change mode_cfg 01→10 at bcid=100 -> active_mode stays 01 until bcid=3563; next cycle is ARM (restart pulse, word_valid=0 one cycle later); then DATA; orbit_count=0.
- In PRBS mode force prbs_bcid off by one at bcid=2000 -> bcid_err=1 next cycle and stays 1 through the next orbit; cleared by the next ARM.
- Assert reset at bcid=1500 in MIX -> next cycle all outputs at reset values, prbs_dis=1, state OFF; re-ARM on next nonzero mode_cfg.
